// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: control-flow and wait sequencer for the 3-stage RV32 core.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles / trap_count counters.
module pipe_ctrl_seq #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_s2,
  input  logic       dmem_req_s2,
  input  logic       dmem_ack,
  input  logic       br_taken,
  input  logic       mret_s2,
  input  logic       irq_pending,
  output logic       stall_s1,
  output logic       stall_s2,
  output logic       flush_s1,
  output logic       flush_s2,
  output logic [1:0] pc_sel,
  output logic       trap_take,
  output logic [1:0] trap_cause,
  output logic       mret_take
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] trap_count
`endif
);

  typedef enum logic [1:0] {
    RUN, MEM_WAIT, TRAP, RET_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic       st1_c, st2_c, fl1_c, fl2_c;
  logic [1:0] pc_c, cause_c;
  logic       trap_c, mret_c;
  logic       irq_go, mem_en, ctl_en;

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and Mealy outputs; irq wins, then mem wait, mret, branch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    st1_c   = 1'b0;
    st2_c   = 1'b0;
    fl1_c   = 1'b0;
    fl2_c   = 1'b0;
    pc_c    = 2'b00;
    cause_c = 2'b00;
    trap_c  = 1'b0;
    mret_c  = 1'b0;
    irq_go  = 1'b0;
    mem_en  = 1'b0;
    ctl_en  = 1'b0;

    unique case (state)
      RUN: begin
        irq_go = valid_s2 & irq_pending;
        mem_en = valid_s2 & ~irq_pending;
        ctl_en = valid_s2 & ~irq_pending;
      end
      RET_HOLD: begin
        state_n = RUN;
        mem_en  = valid_s2;
        ctl_en  = valid_s2;
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_n = RUN;
          cnt_n   = '0;
          ctl_en  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = TRAP;
          cnt_n   = '0;
          trap_c  = 1'b1;
          cause_c = 2'b10;
          fl1_c   = 1'b1;
          fl2_c   = 1'b1;
          pc_c    = 2'b10;
        end else begin
          st1_c = 1'b1;
          st2_c = 1'b1;
          cnt_n = cnt + CNT_ONE;
        end
      end
      TRAP: begin
        state_n = RUN;
      end
    endcase

    if (irq_go) begin
      state_n = TRAP;
      trap_c  = 1'b1;
      cause_c = 2'b01;
      fl1_c   = 1'b1;
      fl2_c   = 1'b1;
      pc_c    = 2'b10;
    end else if (mem_en && dmem_req_s2 && !dmem_ack) begin
      state_n = MEM_WAIT;
      cnt_n   = CNT_ONE;
      st1_c   = 1'b1;
      st2_c   = 1'b1;
    end else if (ctl_en && mret_s2) begin
      state_n = RET_HOLD;
      mret_c  = 1'b1;
      pc_c    = 2'b11;
      fl1_c   = 1'b1;
    end else if (ctl_en && br_taken) begin
      pc_c  = 2'b01;
      fl1_c = 1'b1;
    end
  end

  // Force every output low while reset is held, independent of the clock.
  assign stall_s1   = rst_n & st1_c;
  assign stall_s2   = rst_n & st2_c;
  assign flush_s1   = rst_n & fl1_c;
  assign flush_s2   = rst_n & fl2_c;
  assign pc_sel     = rst_n ? pc_c : 2'b00;
  assign trap_take  = rst_n & trap_c;
  assign trap_cause = rst_n ? cause_c : 2'b00;
  assign mret_take  = rst_n & mret_c;

`ifdef PIPE_CTRL_PERF_EN
  // Saturating stall counter and wrapping trap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      trap_count   <= '0;
    end else begin
      if (stall_s2 && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (trap_take)
        trap_count <= trap_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// tb_pipe_ctrl_seq: directed vector bench for pipe_ctrl_seq.
// Output vector: {s1,s2,f1,f2,pc[1:0],trap,cause[1:0],mret}.
module tb_pipe_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_s2 = 1'b0;
  logic       dmem_req_s2 = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       br_taken = 1'b0;
  logic       mret_s2 = 1'b0;
  logic       irq_pending = 1'b0;
  logic       stall_s1, stall_s2, flush_s1, flush_s2;
  logic [1:0] pc_sel, trap_cause;
  logic       trap_take, mret_take;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] trap_count;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] Z   = 10'b00_00_00_0_00_0;
  localparam logic [9:0] STL = 10'b11_00_00_0_00_0;
  localparam logic [9:0] BR  = 10'b00_10_01_0_00_0;
  localparam logic [9:0] MRT = 10'b00_10_11_0_00_1;
  localparam logic [9:0] IRQ = 10'b00_11_10_1_01_0;
  localparam logic [9:0] TMO = 10'b00_11_10_1_10_0;

  pipe_ctrl_seq #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_s2(valid_s2),
    .dmem_req_s2(dmem_req_s2),
    .dmem_ack(dmem_ack),
    .br_taken(br_taken),
    .mret_s2(mret_s2),
    .irq_pending(irq_pending),
    .stall_s1(stall_s1),
    .stall_s2(stall_s2),
    .flush_s1(flush_s1),
    .flush_s2(flush_s2),
    .pc_sel(pc_sel),
    .trap_take(trap_take),
    .trap_cause(trap_cause),
    .mret_take(mret_take)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .trap_count(trap_count)
`endif
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {stall_s1, stall_s2, flush_s1, flush_s2,
                 pc_sel, trap_take, trap_cause, mret_take};

  typedef struct {
    logic       v, rq, ak, br, mr, iq;
    logic [9:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, rq, ak, br, mr, iq,
                     input logic [9:0] exp, input string nm);
    vec_t e;
    e.v = v; e.rq = rq; e.ak = ak;
    e.br = br; e.mr = mr; e.iq = iq;
    e.exp = exp; e.nm = nm;
    tbl.push_back(e);
  endtask

  task automatic drive(input logic v, rq, ak, br, mr, iq);
    valid_s2 = v; dmem_req_s2 = rq; dmem_ack = ak;
    br_taken = br; mret_s2 = mr; irq_pending = iq;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, got, exp);
    end
  endtask

  // Drive at posedge+1, check mid-cycle, advance to next posedge+1.
  task automatic step(input logic v, rq, ak, br, mr, iq,
                      input logic [9:0] exp, input string nm);
    drive(v, rq, ak, br, mr, iq);
    #3;
    chk(nm, {22'd0, outs}, {22'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    //   v  rq ak br mr iq
    add(0, 0, 0, 0, 0, 0, Z,   "idle");
    add(0, 0, 0, 1, 0, 0, Z,   "br_novalid");
    add(1, 0, 0, 1, 0, 0, BR,  "br_valid");
    add(1, 1, 1, 0, 0, 0, Z,   "ld_zero_wait");
    add(1, 1, 0, 0, 0, 0, STL, "ld_w1");
    add(1, 1, 0, 0, 0, 0, STL, "ld_w2");
    add(1, 1, 0, 0, 0, 0, STL, "ld_w3");
    add(1, 1, 1, 0, 0, 0, Z,   "ld_ack");
    add(1, 0, 0, 1, 0, 1, IRQ, "irq_over_br");
    add(1, 0, 0, 0, 0, 1, Z,   "trap_cycle");
    add(1, 0, 0, 0, 1, 0, MRT, "mret");
    add(1, 0, 0, 0, 0, 1, Z,   "ret_hold_noirq");
    add(1, 0, 0, 0, 0, 1, IRQ, "irq_after_hold");
    add(1, 0, 0, 0, 0, 0, Z,   "trap_cycle2");
    add(1, 1, 0, 0, 0, 1, IRQ, "irq_over_mem");
    add(1, 1, 0, 0, 0, 0, Z,   "trap_cycle3");
    add(1, 0, 0, 1, 1, 0, MRT, "mret_over_br");
    add(1, 1, 0, 0, 0, 1, STL, "hold_mem");
    add(1, 1, 0, 0, 0, 1, STL, "wait_irq_ign");
    add(1, 1, 1, 1, 0, 0, BR,  "ack_br");
    add(1, 0, 0, 0, 0, 0, Z,   "run_plain");
    add(1, 0, 0, 0, 1, 0, MRT, "mret2");
    add(1, 0, 0, 1, 0, 0, BR,  "hold_br");
    add(1, 1, 0, 0, 0, 0, STL, "ld_w1b");
    add(1, 1, 1, 0, 1, 0, MRT, "ack_mret");
    add(0, 0, 0, 0, 0, 0, Z,   "hold_novalid");
    add(1, 0, 0, 0, 1, 1, IRQ, "irq_over_mret");
    add(0, 0, 0, 0, 0, 0, Z,   "trap_cycle4");

    drive(1, 1, 0, 1, 1, 1);
    #12;
    chk("in_reset", {22'd0, outs}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      step(tbl[i].v, tbl[i].rq, tbl[i].ak, tbl[i].br,
           tbl[i].mr, tbl[i].iq, tbl[i].exp, tbl[i].nm);

    for (int i = 0; i < 15; i++)
      step(1, 1, 0, 0, 0, 0, STL, "tmo_stall");
    step(1, 1, 0, 0, 0, 0, TMO, "tmo_trap");
    step(1, 1, 0, 0, 0, 0, Z,   "tmo_after");
    step(0, 0, 0, 0, 0, 0, Z,   "tmo_idle");

    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 0, 0, 0, STL, "rst_pre_wait");
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cycles", stall_cycles, 32'd24);
    chk("trap_count", {16'd0, trap_count}, 32'd5);
`endif
    drive(1, 1, 0, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {22'd0, outs}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_trap_count", {16'd0, trap_count}, 32'd0);
`endif
    @(posedge clk); #2;
    chk("rst_held_outs", {22'd0, outs}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 1, 0, 0, BR, "post_rst_run");
    for (int i = 0; i < 15; i++)
      step(1, 1, 0, 0, 0, 0, STL, "post_rst_stall");
    step(1, 1, 0, 0, 0, 0, TMO, "post_rst_tmo");
    step(0, 0, 0, 0, 0, 0, Z,   "post_rst_trap");
`ifdef PIPE_CTRL_PERF_EN
    chk("post_stall_cycles", stall_cycles, 32'd15);
    chk("post_trap_count", {16'd0, trap_count}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
